// File: rtl/conv_regs_reader.sv
// conv_regs_reader: burst read-back engine for the 4x16-bit conversion register file.
// Turns a byte-level burst request into word reads (RE_B/ADD_B/DAT_B) and streams the
// bytes out over a valid/ready byte channel. Even byte address = high byte, odd = low byte.
// Optional feature macro: CONV_REGS_RD_CSUM_EN appends an XOR checksum byte to each burst.
`timescale 1ns/1ps
module conv_regs_reader #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [2:0]  REQ_ADD,
    input  logic [3:0]  REQ_LEN,
    output logic        BUSY,
    output logic        RE_B,
    output logic [1:0]  ADD_B,
    input  logic [15:0] DAT_B,
    output logic [7:0]  TX_DAT,
    output logic        TX_VAL,
    input  logic        TX_RDY,
    output logic        DONE
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY);

`ifdef CONV_REGS_RD_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_DONE, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_DONE} state_t;
`endif

    state_t      state_q;
    logic [2:0]  addr_q;
    logic [3:0]  cnt_q;
    logic [15:0] snap_q;
    logic [1:0]  waitc_q;
    logic        busy_q;
    logic        re_b_q;
    logic [1:0]  add_b_q;
    logic        tx_val_q;
    logic        done_q;
`ifdef CONV_REGS_RD_CSUM_EN
    logic [7:0]  csum_q;
`endif

    logic [2:0]  addr_inc_d;
    logic [7:0]  tx_byte_d;

    assign addr_inc_d = addr_q + 3'd1;

    // Outgoing byte is selected from the coherent snapshot (or the checksum) by register state only.
    always_comb begin
        tx_byte_d = addr_q[0] ? snap_q[7:0] : snap_q[15:8];
`ifdef CONV_REGS_RD_CSUM_EN
        if (state_q == S_CSUM) begin
            tx_byte_d = csum_q;
        end
`endif
    end

    // Burst control FSM with registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            snap_q   <= '0;
            waitc_q  <= '0;
            busy_q   <= 1'b0;
            re_b_q   <= 1'b0;
            add_b_q  <= '0;
            tx_val_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef CONV_REGS_RD_CSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (REQ && (REQ_LEN != 4'd0)) begin
                        addr_q  <= REQ_ADD;
                        cnt_q   <= REQ_LEN;
                        busy_q  <= 1'b1;
                        re_b_q  <= 1'b1;
                        add_b_q <= REQ_ADD[2:1];
                        state_q <= S_FETCH;
`ifdef CONV_REGS_RD_CSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    re_b_q  <= 1'b0;
                    waitc_q <= WAIT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    waitc_q <= waitc_q - 2'd1;
                    // Count reaches zero on this edge: read data is valid now.
                    if (waitc_q == 2'd1) begin
                        snap_q   <= DAT_B;
                        tx_val_q <= 1'b1;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (TX_RDY) begin
                        addr_q <= addr_inc_d;
                        cnt_q  <= cnt_q - 4'd1;
`ifdef CONV_REGS_RD_CSUM_EN
                        csum_q <= csum_q ^ tx_byte_d;
`endif
                        if (cnt_q == 4'd1) begin
`ifdef CONV_REGS_RD_CSUM_EN
                            state_q  <= S_CSUM;
`else
                            tx_val_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
`endif
                        end else if (addr_q[0]) begin
                            // Next byte starts a new word: fetch a fresh snapshot.
                            tx_val_q <= 1'b0;
                            re_b_q   <= 1'b1;
                            add_b_q  <= addr_inc_d[2:1];
                            state_q  <= S_FETCH;
                        end
                    end
                end
`ifdef CONV_REGS_RD_CSUM_EN
                S_CSUM: begin
                    if (TX_RDY) begin
                        tx_val_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    re_b_q   <= 1'b0;
                    tx_val_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign RE_B   = re_b_q;
    assign ADD_B  = add_b_q;
    assign TX_DAT = tx_byte_d;
    assign TX_VAL = tx_val_q;
    assign DONE   = done_q;

endmodule
